// File: rtl/cmac_pkg.sv
// Shared constants and types for the complex MAC feeder.
// The MAC stage uses the same latency default.
package cmac_pkg;

  localparam int GROUP_SIZE = 4;
  localparam int PAIR_W = $clog2(GROUP_SIZE);
  localparam int MAC_LATENCY_DEFAULT = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_FEED,
    ST_GAP,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cmac_group_feeder_if.sv
// Operand-pair stream into the feeder.
// Valid/ready handshake, four signed operands per beat.
interface cmac_group_feeder_if #(
  parameter int N = 16
);

  logic                s_valid;
  logic                s_ready;
  logic signed [N-1:0] s_ar;
  logic signed [N-1:0] s_ai;
  logic signed [N-1:0] s_br;
  logic signed [N-1:0] s_bi;

  modport master (
    output s_valid,
    output s_ar,
    output s_ai,
    output s_br,
    output s_bi,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_ar,
    input  s_ai,
    input  s_br,
    input  s_bi,
    output s_ready
  );

endinterface

// File: rtl/cmac_delay_line.sv
// 1-bit shift register of DEPTH stages.
// Output is the input delayed by exactly DEPTH cycles.
module cmac_delay_line #(
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_d;
  logic [DEPTH-1:0] sr_q;

  // shift one stage per cycle
  always_comb begin
    sr_d = {sr_q[DEPTH-2:0], din};
  end

  // stage registers, cleared on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/cmac_group_feeder.sv
// Issues operand pairs to the complex MAC in groups of four,
// schedules accumulator clears and checks returned results.
module cmac_group_feeder
  import cmac_pkg::*;
#(
  parameter int N           = 16,
  parameter int MAC_LATENCY = MAC_LATENCY_DEFAULT,
  parameter int GRP_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [GRP_W-1:0]    n_groups,
  output logic                busy,
  output logic                done,
  output logic                err,
  cmac_group_feeder_if.slave  s,
  output logic                mac_en,
  output logic                mac_clear,
  output logic signed [N-1:0] in_ar,
  output logic signed [N-1:0] in_ai,
  output logic signed [N-1:0] in_br,
  output logic signed [N-1:0] in_bi,
  input  logic                mac_result_valid
);

  state_e state_d, state_q;

  logic busy_d, busy_q;
  logic done_d, done_q;
  logic err_d, err_q;
  logic rdy_d, rdy_q;
  logic en_d, en_q;
  logic last_d, last_q;
  logic iclr_d, iclr_q;

  logic signed [N-1:0] ar_d, ar_q;
  logic signed [N-1:0] ai_d, ai_q;
  logic signed [N-1:0] br_d, br_q;
  logic signed [N-1:0] bi_d, bi_q;

  logic [GRP_W-1:0]  ngrp_d, ngrp_q;
  logic [GRP_W-1:0]  iss_d, iss_q;
  logic [GRP_W-1:0]  ret_d, ret_q;
  logic [PAIR_W-1:0] pair_d, pair_q;

  logic hs;
  logic pair_last;
  logic tap;

  assign hs        = s.s_valid & rdy_q;
  assign pair_last = (pair_q == PAIR_W'(GROUP_SIZE - 1));

  // tag of each group's last mac_en, delayed to the result slot
  cmac_delay_line #(
    .DEPTH (MAC_LATENCY + 1)
  ) u_clr_dl (
    .clk  (clk),
    .rst  (rst),
    .din  (last_q),
    .dout (tap)
  );

  // next-state, handshake capture and result bookkeeping
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rdy_d   = rdy_q;
    en_d    = 1'b0;
    last_d  = 1'b0;
    iclr_d  = 1'b0;
    ar_d    = ar_q;
    ai_d    = ai_q;
    br_d    = br_q;
    bi_d    = bi_q;
    ngrp_d  = ngrp_q;
    iss_d   = iss_q;
    pair_d  = pair_q;
    ret_d   = ret_q + GRP_W'(tap);

    // a missing or unexpected result both poison the job
    if (tap ^ mac_result_valid) begin
      err_d = 1'b1;
    end

    if (hs) begin
      ar_d   = s.s_ar;
      ai_d   = s.s_ai;
      br_d   = s.s_br;
      bi_d   = s.s_bi;
      en_d   = 1'b1;
      pair_d = pair_q + 1'b1;
      if (pair_last) begin
        last_d = 1'b1;
        pair_d = '0;
        iss_d  = iss_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          busy_d  = 1'b1;
          iclr_d  = 1'b1;
          ngrp_d  = n_groups;
          err_d   = 1'b0;
          iss_d   = '0;
          ret_d   = '0;
          pair_d  = '0;
        end
      end
      ST_INIT: begin
        if (ngrp_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FEED;
          rdy_d   = 1'b1;
        end
      end
      ST_FEED: begin
        if (hs && pair_last) begin
          state_d = ST_GAP;
          rdy_d   = 1'b0;
        end
      end
      ST_GAP: begin
        if (iss_q == ngrp_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FEED;
          rdy_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (ret_d == ngrp_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      iclr_q  <= 1'b0;
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
      ngrp_q  <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      en_q    <= en_d;
      last_q  <= last_d;
      iclr_q  <= iclr_d;
      ar_q    <= ar_d;
      ai_q    <= ai_d;
      br_q    <= br_d;
      bi_q    <= bi_d;
      ngrp_q  <= ngrp_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      pair_q  <= pair_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign s.s_ready = rdy_q;
  assign mac_en    = en_q;
  assign mac_clear = iclr_q | tap;
  assign in_ar     = ar_q;
  assign in_ai     = ai_q;
  assign in_br     = br_q;
  assign in_bi     = bi_q;

endmodule

// File: tb/tb_cmac_group_feeder.sv
// Bench for cmac_group_feeder: job table, MAC model,
// reference group sums and a mid-job reset sequence.
module tb_cmac_group_feeder;

  localparam int N = 16;
  localparam int F_NONE = 0;
  localparam int F_EXTRA = 1;
  localparam int F_SUP = 2;

  typedef struct {
    int g;
    int pct;
    int fault;
    bit ones;
    bit exp_err;
    int exp_en;
    int exp_res;
    int exp_clr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [7:0] n_groups = '0;
  logic busy, done, err, mac_en, mac_clear;
  logic signed [N-1:0] in_ar, in_ai, in_br, in_bi;
  logic mac_result_valid;

  cmac_group_feeder_if #(.N(N)) s_if ();

  cmac_group_feeder #(
    .N           (N),
    .MAC_LATENCY (6),
    .GRP_W       (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .n_groups         (n_groups),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .s                (s_if),
    .mac_en           (mac_en),
    .mac_clear        (mac_clear),
    .in_ar            (in_ar),
    .in_ai            (in_ai),
    .in_br            (in_br),
    .in_bi            (in_bi),
    .mac_result_valid (mac_result_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // driver-owned controls read by the model
  bit inj_extra = 1'b0;
  int sup_idx = -1;
  int init_cyc = -1;

  // model-owned state
  bit     pv_ring[16];
  longint pr_re[16];
  longint pr_im[16];
  bit     rv_ring[16];
  longint acc_re, acc_im;
  int     en_total = 0;
  int     rv_total = 0;
  int     clr_cnt = 0;
  int     clr_bad = 0;
  int     col_bad = 0;
  int     done_cnt = 0;
  int     done_cyc = 0;
  int     hs_cyc[$];
  longint hs_re[$];
  longint hs_im[$];
  int     en_cyc[$];
  longint res_re[$];
  longint res_im[$];

  // Q8 complex product, as the MAC forms it
  function automatic longint p_re(longint ar, longint ai,
                                  longint br, longint bi);
    return (ar * br - ai * bi) >>> 8;
  endfunction

  function automatic longint p_im(longint ar, longint ai,
                                  longint br, longint bi);
    return (ar * bi + ai * br) >>> 8;
  endfunction

  // MAC behaviour plus clear/result scheduling checks
  always @(negedge clk) begin
    bit pv, rv, drv;
    int sl;
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        pv_ring[i] = 1'b0;
        rv_ring[i] = 1'b0;
      end
      acc_re = 0;
      acc_im = 0;
      en_total = 0;
      mac_result_valid = 1'b0;
    end else begin
      if (s_if.s_valid && s_if.s_ready) begin
        hs_cyc.push_back(cyc);
        hs_re.push_back(p_re(s_if.s_ar, s_if.s_ai,
                             s_if.s_br, s_if.s_bi));
        hs_im.push_back(p_im(s_if.s_ar, s_if.s_ai,
                             s_if.s_br, s_if.s_bi));
      end
      if (mac_en) begin
        sl = (cyc + 6) % 16;
        pv_ring[sl] = 1'b1;
        pr_re[sl] = p_re(in_ar, in_ai, in_br, in_bi);
        pr_im[sl] = p_im(in_ar, in_ai, in_br, in_bi);
        en_total++;
        en_cyc.push_back(cyc);
        if (en_total % 4 == 0) rv_ring[(cyc + 7) % 16] = 1'b1;
      end
      sl = cyc % 16;
      pv = pv_ring[sl];
      pv_ring[sl] = 1'b0;
      if (pv) begin
        acc_re += pr_re[sl];
        acc_im += pr_im[sl];
      end
      rv = rv_ring[sl];
      rv_ring[sl] = 1'b0;
      if (mac_clear) clr_cnt++;
      if (mac_clear != (rv || cyc == init_cyc)) clr_bad++;
      if (mac_clear && pv) col_bad++;
      drv = 1'b0;
      if (rv) begin
        res_re.push_back(acc_re);
        res_im.push_back(acc_im);
        drv = (rv_total != sup_idx);
        rv_total++;
      end
      if (inj_extra) drv = 1'b1;
      mac_result_valid = drv;
      if (mac_clear) begin
        acc_re = 0;
        acc_im = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(vec_t v, bit prev_err);
    int s_cyc, hs0, en0, res0, clr0, done0;
    int idx, guard, last_hs;
    bit pend, hsok;
    longint sr, si;
    chk("err_sticky", err, prev_err);
    hs0 = hs_cyc.size();
    en0 = en_cyc.size();
    res0 = res_re.size();
    clr0 = clr_cnt;
    done0 = done_cnt;
    sup_idx = (v.fault == F_SUP) ? rv_total : -1;
    start = 1'b1;
    n_groups = 8'(v.g);
    s_cyc = cyc;
    init_cyc = cyc + 1;
    tick();
    start = 1'b0;
    chk("init_busy", busy, 1);
    chk("init_err_clr", err, 0);
    idx = 0;
    pend = 1'b0;
    guard = 0;
    while (idx < 4 * v.g && guard < 2000) begin
      if (!pend && int'($urandom_range(99)) < v.pct) begin
        if (v.ones) begin
          s_if.s_ar = 16'sd256;
          s_if.s_ai = 16'sd256;
          s_if.s_br = 16'sd256;
          s_if.s_bi = 16'sd256;
        end else begin
          s_if.s_ar = 16'($urandom());
          s_if.s_ai = 16'($urandom());
          s_if.s_br = 16'($urandom());
          s_if.s_bi = 16'($urandom());
        end
        pend = 1'b1;
      end
      s_if.s_valid = pend;
      hsok = pend && s_if.s_ready;
      tick();
      guard++;
      if (hsok) begin
        idx++;
        pend = 1'b0;
      end
    end
    s_if.s_valid = 1'b0;
    chk("feed_count", idx, 4 * v.g);
    if (v.fault == F_EXTRA) begin
      repeat (3) tick();
      inj_extra = 1'b1;
      tick();
      inj_extra = 1'b0;
    end
    guard = 0;
    while (done_cnt == done0 && guard < 200) begin
      tick();
      guard++;
    end
    chk("done_seen", longint'(done_cnt != done0), 1);
    repeat (3) tick();
    chk("done_pulses", done_cnt - done0, 1);
    chk("busy_after", busy, 0);
    chk("err_final", err, v.exp_err);
    chk("mac_en_cnt", en_cyc.size() - en0, v.exp_en);
    chk("result_cnt", res_re.size() - res0, v.exp_res);
    chk("clear_cnt", clr_cnt - clr0, v.exp_clr);
    chk("clear_sched", clr_bad, 0);
    chk("clear_vs_pv", col_bad, 0);
    if (res_re.size() - res0 == v.g &&
        hs_cyc.size() - hs0 == 4 * v.g) begin
      for (int g = 0; g < v.g; g++) begin
        sr = 0;
        si = 0;
        for (int k = 0; k < 4; k++) begin
          sr += hs_re[hs0 + 4 * g + k];
          si += hs_im[hs0 + 4 * g + k];
        end
        chk("grp_sum_re", res_re[res0 + g], sr);
        chk("grp_sum_im", res_im[res0 + g], si);
      end
      if (v.ones && v.g > 0) begin
        chk("ones_re", res_re[res0], 0);
        chk("ones_im", res_im[res0], 2048);
      end
    end
    if (v.pct == 100 && v.fault != F_SUP) begin
      if (v.g == 0) begin
        chk("g0_done_lat", done_cyc - s_cyc, 2);
      end else if (hs_cyc.size() - hs0 == 4 * v.g &&
                   en_cyc.size() - en0 == 4 * v.g) begin
        last_hs = hs_cyc[hs0 + 4 * v.g - 1];
        chk("last_hs_lat", last_hs - s_cyc, 5 * v.g);
        chk("done_lat", done_cyc - last_hs, 9);
        for (int g = 1; g < v.g; g++) begin
          chk("grp_gap", en_cyc[en0 + 4 * g] -
                         en_cyc[en0 + 4 * g - 1], 2);
        end
      end
    end
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1, 100, F_NONE, 1'b1, 1'b0, 4, 1, 2};
    tbl[1] = '{0, 100, F_NONE, 1'b0, 1'b0, 0, 0, 1};
    tbl[2] = '{2, 100, F_NONE, 1'b0, 1'b0, 8, 2, 3};
    tbl[3] = '{3, 60, F_NONE, 1'b0, 1'b0, 12, 3, 4};
    tbl[4] = '{3, 100, F_EXTRA, 1'b0, 1'b1, 12, 3, 4};
    tbl[5] = '{2, 70, F_SUP, 1'b0, 1'b1, 8, 2, 3};
    tbl[6] = '{4, 50, F_NONE, 1'b0, 1'b0, 16, 4, 5};

    s_if.s_valid = 1'b0;
    s_if.s_ar = '0;
    s_if.s_ai = '0;
    s_if.s_br = '0;
    s_if.s_bi = '0;

    repeat (3) tick();
    chk("rst_ctrl", {busy, done, err, s_if.s_ready,
                     mac_en, mac_clear}, 0);
    chk("rst_data", in_ar | in_ai | in_br | in_bi, 0);
    rst = 1'b1;
    repeat (2) tick();
    chk("idle_ready", s_if.s_ready, 0);

    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i], (i == 0) ? 1'b0 : tbl[i - 1].exp_err);
      repeat (2) tick();
    end

    // reset in FEED after two pairs were accepted
    start = 1'b1;
    n_groups = 8'd2;
    init_cyc = cyc + 1;
    tick();
    start = 1'b0;
    s_if.s_ar = 16'sd7;
    s_if.s_ai = 16'sd3;
    s_if.s_br = -16'sd5;
    s_if.s_bi = 16'sd9;
    s_if.s_valid = 1'b1;
    repeat (3) tick();
    s_if.s_valid = 1'b0;
    chk("pre_rst_en", mac_en, 1);
    chk("pre_rst_ar", in_ar, 7);
    rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {busy, done, err, s_if.s_ready,
                         mac_en, mac_clear}, 0);
    chk("mid_rst_data", in_ar | in_ai | in_br | in_bi, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", s_if.s_ready, 0);
    chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
